// File: rtl/e203_exu_oitf_trk_pkg.sv
// Shared types and sizing for the OITF tracker.
// The optional E203_OITF_FPU_EN macro adds FP-regfile tagging to every entry and compare.
package e203_exu_oitf_trk_pkg;

  localparam int unsigned OitfDepth = 2;
  localparam int unsigned ItagW     = $clog2(OitfDepth);
  localparam int unsigned RfidxW    = 5;
  localparam int unsigned PcW       = 32;
  localparam int unsigned NumSrc    = 4;

  // Slot order of the per-entry compare vector.
  typedef enum logic [1:0] {
    SrcRs1 = 2'd0,
    SrcRs2 = 2'd1,
    SrcRs3 = 2'd2,
    SrcRd  = 2'd3
  } src_e;

  typedef struct packed {
    logic [RfidxW-1:0] rdidx;
    logic [PcW-1:0]    pc;
    logic              rdwen;
    logic              rdfpu;
  } oitf_ent_t;

  // Depth is a power of two, so the carry out of the index lands in the wrap bit.
  function automatic logic [ItagW:0] ptr_inc(input logic [ItagW:0] ptr);
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/e203_exu_oitf_trk_if.sv
// Dispatch / retire / hazard bundle between the EXU control and the OITF.
interface e203_exu_oitf_trk_if;
  import e203_exu_oitf_trk_pkg::*;

  logic              dis_ena;
  logic              dis_ready;
  logic [ItagW-1:0]  dis_ptr;
  logic [RfidxW-1:0] disp_i_rdidx;
  logic              disp_i_rdwen;
  logic              disp_i_rdfpu;
  logic [PcW-1:0]    disp_i_pc;
  logic              disp_i_rs1en;
  logic              disp_i_rs2en;
  logic              disp_i_rs3en;
  logic [RfidxW-1:0] disp_i_rs1idx;
  logic [RfidxW-1:0] disp_i_rs2idx;
  logic [RfidxW-1:0] disp_i_rs3idx;
  logic              disp_i_rs1fpu;
  logic              disp_i_rs2fpu;
  logic              disp_i_rs3fpu;
  logic              oitfrd_match_disprs1;
  logic              oitfrd_match_disprs2;
  logic              oitfrd_match_disprs3;
  logic              oitfrd_match_disprd;
  logic              ret_ena;
  logic [ItagW-1:0]  ret_ptr;
  logic [RfidxW-1:0] ret_rdidx;
  logic [PcW-1:0]    ret_pc;
  logic              ret_rdwen;
  logic              ret_rdfpu;
  logic              oitf_empty;

  modport master (
    output dis_ena, disp_i_rdidx, disp_i_rdwen, disp_i_rdfpu, disp_i_pc,
           disp_i_rs1en, disp_i_rs2en, disp_i_rs3en,
           disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx,
           disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, ret_ena,
    input  dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprs3, oitfrd_match_disprd,
           ret_ptr, ret_rdidx, ret_pc, ret_rdwen, ret_rdfpu, oitf_empty
  );

  modport slave (
    input  dis_ena, disp_i_rdidx, disp_i_rdwen, disp_i_rdfpu, disp_i_pc,
           disp_i_rs1en, disp_i_rs2en, disp_i_rs3en,
           disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx,
           disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, ret_ena,
    output dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprs3, oitfrd_match_disprd,
           ret_ptr, ret_rdidx, ret_pc, ret_rdwen, ret_rdfpu, oitf_empty
  );

endinterface

// File: rtl/e203_exu_oitf_ent.sv
// One OITF entry: valid flag, destination fields and its compare against each dispatch source.
// rdfpu storage exists only when E203_OITF_FPU_EN is defined.
module e203_exu_oitf_ent
  import e203_exu_oitf_trk_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_set,
  input  logic                          i_clr,
  input  oitf_ent_t                     i_ent,
  input  logic [NumSrc-1:0][RfidxW-1:0] i_src_idx,
  input  logic [NumSrc-1:0]             i_src_fpu,
  output oitf_ent_t                     o_ent,
  output logic [NumSrc-1:0]             o_hit
);

  logic              r_vld;
  logic              r_rdwen;
  logic [RfidxW-1:0] r_rdidx;
  logic [PcW-1:0]    r_pc;
  logic              w_rdfpu;
  logic [NumSrc-1:0] w_fpu_eq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_rdwen <= 1'b0;
      r_rdidx <= '0;
      r_pc    <= '0;
    end else if (i_set) begin
      r_vld   <= 1'b1;
      r_rdwen <= i_ent.rdwen;
      r_rdidx <= i_ent.rdidx;
      r_pc    <= i_ent.pc;
    end else if (i_clr) begin
      r_vld   <= 1'b0;
    end
  end

`ifdef E203_OITF_FPU_EN
  logic r_rdfpu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdfpu <= 1'b0;
    end else if (i_set) begin
      r_rdfpu <= i_ent.rdfpu;
    end
  end

  assign w_rdfpu  = r_rdfpu;
  assign w_fpu_eq = ~({NumSrc{r_rdfpu}} ^ i_src_fpu);
`else
  logic w_unused_fpu;

  assign w_rdfpu      = 1'b0;
  assign w_fpu_eq     = '1;
  assign w_unused_fpu = ^{i_ent.rdfpu, i_src_fpu};
`endif

  assign o_ent = '{rdidx: r_rdidx, pc: r_pc, rdwen: r_rdwen, rdfpu: w_rdfpu};

  always_comb begin
    o_hit = '0;
    for (int s = 0; s < NumSrc; s++) begin
      o_hit[s] = r_vld & r_rdwen & (r_rdidx == i_src_idx[s]) & w_fpu_eq[s];
    end
  end

endmodule

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding Instruction Track FIFO: in-order alloc/retire of long-pipe instrs plus RAW/WAW check.
// E203_OITF_FPU_EN enables FP-regfile tagging and the rs3 hazard check.
module e203_exu_oitf_trk
  import e203_exu_oitf_trk_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  e203_exu_oitf_trk_if.slave io_oitf
);

  logic [ItagW:0]                r_alc_ptr;
  logic [ItagW:0]                r_ret_ptr;
  logic [ItagW-1:0]              w_alc_idx;
  logic [ItagW-1:0]              w_ret_idx;
  logic                          w_empty;
  logic                          w_full;
  logic                          w_alc_ena;
  logic                          w_ret_ena;
  oitf_ent_t                     w_disp_ent;
  logic [NumSrc-1:0][RfidxW-1:0] w_src_idx;
  logic [NumSrc-1:0]             w_src_fpu;
  oitf_ent_t                     w_ent [OitfDepth];
  logic [NumSrc-1:0]             w_hit [OitfDepth];
  logic [NumSrc-1:0]             w_hit_any;

  assign w_alc_idx = r_alc_ptr[ItagW-1:0];
  assign w_ret_idx = r_ret_ptr[ItagW-1:0];
  assign w_empty   = (w_alc_idx == w_ret_idx) & (r_alc_ptr[ItagW] == r_ret_ptr[ItagW]);
  assign w_full    = (w_alc_idx == w_ret_idx) & (r_alc_ptr[ItagW] != r_ret_ptr[ItagW]);
  // Ready depends on state only, so a same-cycle retire never opens a slot.
  assign w_alc_ena = io_oitf.dis_ena & ~w_full;
  assign w_ret_ena = io_oitf.ret_ena & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
    end else begin
      if (w_alc_ena) r_alc_ptr <= ptr_inc(r_alc_ptr);
      if (w_ret_ena) r_ret_ptr <= ptr_inc(r_ret_ptr);
    end
  end

  assign w_disp_ent = '{rdidx: io_oitf.disp_i_rdidx, pc: io_oitf.disp_i_pc,
                        rdwen: io_oitf.disp_i_rdwen, rdfpu: io_oitf.disp_i_rdfpu};
  assign w_src_idx  = {io_oitf.disp_i_rdidx, io_oitf.disp_i_rs3idx,
                       io_oitf.disp_i_rs2idx, io_oitf.disp_i_rs1idx};
  assign w_src_fpu  = {io_oitf.disp_i_rdfpu, io_oitf.disp_i_rs3fpu,
                       io_oitf.disp_i_rs2fpu, io_oitf.disp_i_rs1fpu};

  for (genvar g = 0; g < OitfDepth; g++) begin : g_ent
    e203_exu_oitf_ent u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_set     (w_alc_ena & (w_alc_idx == ItagW'(g))),
      .i_clr     (w_ret_ena & (w_ret_idx == ItagW'(g))),
      .i_ent     (w_disp_ent),
      .i_src_idx (w_src_idx),
      .i_src_fpu (w_src_fpu),
      .o_ent     (w_ent[g]),
      .o_hit     (w_hit[g])
    );
  end

  always_comb begin
    w_hit_any = '0;
    for (int i = 0; i < OitfDepth; i++) begin
      w_hit_any = w_hit_any | w_hit[i];
    end
  end

  assign io_oitf.dis_ready  = ~w_full;
  assign io_oitf.dis_ptr    = w_alc_idx;
  assign io_oitf.ret_ptr    = w_ret_idx;
  assign io_oitf.ret_rdidx  = w_ent[w_ret_idx].rdidx;
  assign io_oitf.ret_pc     = w_ent[w_ret_idx].pc;
  assign io_oitf.ret_rdwen  = w_ent[w_ret_idx].rdwen;
  assign io_oitf.ret_rdfpu  = w_ent[w_ret_idx].rdfpu;
  assign io_oitf.oitf_empty = w_empty;

  assign io_oitf.oitfrd_match_disprs1 = io_oitf.disp_i_rs1en & w_hit_any[SrcRs1];
  assign io_oitf.oitfrd_match_disprs2 = io_oitf.disp_i_rs2en & w_hit_any[SrcRs2];
  assign io_oitf.oitfrd_match_disprd  = io_oitf.disp_i_rdwen & w_hit_any[SrcRd];
`ifdef E203_OITF_FPU_EN
  assign io_oitf.oitfrd_match_disprs3 = io_oitf.disp_i_rs3en & w_hit_any[SrcRs3];
`else
  logic w_unused_rs3;

  assign io_oitf.oitfrd_match_disprs3 = 1'b0;
  assign w_unused_rs3 = ^{io_oitf.disp_i_rs3en, w_hit_any[SrcRs3]};
`endif

  ret_on_empty_a: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(io_oitf.ret_ena && w_empty));

endmodule
